// File: rtl/mips_bus_pkg.sv
// Shared MIPS data-bus constants and types used by the data memory and the address decoder.
package mips_bus_pkg;

  localparam logic [31:0] DMEM_BASE  = 32'h0000_0500;
  localparam logic [31:0] DMEM_LAST  = 32'h0000_08FF;
  localparam int unsigned DMEM_DEPTH = 256;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  // One accepted bus access, held for the duration of the wait states.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte-lane synchronous write and combinational read port.
module dmem_array
  import mips_bus_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [BE_W-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Chip-selected data memory on the MIPS data bus: accepts one access, waits a fixed
// number of cycles, then pulses Ready (with Error for misaligned addresses).
module data_mem_responder
  import mips_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DMEM_BASE,
  parameter int unsigned       DEPTH_WORDS = DMEM_DEPTH,
  parameter int unsigned       WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              Req,
  input  logic [ADDR_W-1:0] Address,
  input  logic              WE,
  input  logic [BE_W-1:0]   BE,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Error,
  output logic              Busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;

  bus_req_t          cur_c;
  logic              accept_c;
  logic              enter_resp_c;
  logic              misaligned_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] mem_rdata_c;

  // With zero wait states the response edge is the accept edge, so use the live bus.
  always_comb begin
    cur_c.addr   = Address;
    cur_c.we     = WE;
    cur_c.be     = BE;
    cur_c.wdata  = WriteData;
    if (state_q != IDLE) cur_c = req_q;

    accept_c     = (state_q == IDLE) && Req && CS;
    enter_resp_c = (accept_c && (WAIT_STATES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == CNT_W'(WAIT_STATES)));
    misaligned_c = (cur_c.addr[1:0] != 2'b00);
    mem_we_c     = enter_resp_c && cur_c.we && !misaligned_c;
    idx_c        = IDX_W'((cur_c.addr - BASE_ADDR) >> 2);
  end

  dmem_array #(
    .DEPTH (DEPTH_WORDS)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we_c),
    .be    (cur_c.be),
    .idx   (idx_c),
    .wdata (cur_c.wdata),
    .rdata (mem_rdata_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          req_d   = cur_c;
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q != CNT_W'(WAIT_STATES)) cnt_d = cnt_q + CNT_W'(1);
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Response edge: commit write (via mem_we_c), capture read data and flags.
    if (enter_resp_c) begin
      state_d = RESP;
      ready_d = 1'b1;
      error_d = misaligned_c;
      if (misaligned_c)   rdata_d = '0;
      else if (!cur_c.we) rdata_d = mem_rdata_c;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign ReadData = rdata_q;
  assign Ready    = ready_q;
  assign Error    = error_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

  localparam int unsigned WS   = 2;
  localparam logic [31:0] BASE = 32'h0000_0500;

  logic        CLK = 1'b0;
  logic        RST, CS, Req, WE;
  logic [31:0] Address, WriteData, ReadData;
  logic [3:0]  BE;
  logic        Ready, Error, Busy;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  // Reference model: memory words and the value ReadData should currently hold.
  logic [31:0] mem_m [256];
  logic [31:0] rd_m;

  data_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (256),
    .WAIT_STATES (WS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CS        (CS),
    .Req       (Req),
    .Address   (Address),
    .WE        (WE),
    .BE        (BE),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Ready     (Ready),
    .Error     (Error),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    Req = 1'b0; CS = 1'b0; WE = 1'b0; BE = 4'h0; Address = '0; WriteData = '0;
  endtask

  function automatic void model_access(input logic [31:0] a, input logic we,
                                       input logic [3:0] be, input logic [31:0] wd,
                                       output logic err);
    int unsigned w;
    w   = ((a - BASE) / 4) % 256;
    err = (a % 4) != 0;
    if (err) rd_m = 32'h0;
    else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[w][8*b +: 8] = wd[8*b +: 8];
    end else rd_m = mem_m[w];
  endfunction

  // Issue one access; report latency (cycle 0 = Req cycle), flags and protocol violations.
  task automatic do_access(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, output int lat, output logic err,
                           output logic [31:0] rd, output int prot, output int unsigned rcyc);
    Req = 1'b1; CS = 1'b1; Address = a; WE = we; BE = be; WriteData = wd;
    tick();
    drive_idle();
    lat = -1; err = 1'b0; rd = 'x; prot = 0; rcyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (Busy !== 1'b1) prot++;
      if (Ready === 1'b1) begin
        lat = c; err = Error; rd = ReadData; rcyc = cyc;
        break;
      end
      if (Error !== 1'b0) prot++;
      tick();
    end
    tick();
    if (Ready !== 1'b0 || Error !== 1'b0 || Busy !== 1'b0) prot++;
  endtask

  task automatic test_reset();
    drive_idle();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    rd_m = 32'h0;
    total++; if (Ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", Ready); end
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", Error); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if (ReadData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", ReadData); end
  endtask

  task automatic test_cs_low();
    int seen = 0;
    Req = 1'b1; CS = 1'b0; Address = 32'h600; WE = 1'b0; BE = 4'hF;
    tick();
    drive_idle();
    for (int c = 0; c < 10; c++) begin
      if (Ready !== 1'b0 || Busy !== 1'b0) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL cs_low_ignored got=%0d want=0", seen); end
  endtask

  task automatic test_roundtrip();
    logic [31:0] a_t [2] = '{32'h500, 32'h500};
    logic        w_t [2] = '{1'b1, 1'b0};
    int lat, prot; logic err, xe; logic [31:0] rd; int unsigned rc;
    for (int i = 0; i < 2; i++) begin
      do_access(a_t[i], w_t[i], 4'hF, 32'hDEADBEEF, lat, err, rd, prot, rc);
      model_access(a_t[i], w_t[i], 4'hF, 32'hDEADBEEF, xe);
      total++;
      if ({8'(lat), err, rd, 8'(prot)} !== {8'(WS + 1), xe, rd_m, 8'd0}) begin
        bad++;
        $display("FAIL roundtrip[%0d] got lat=%0d err=%b rd=%h prot=%0d want lat=%0d err=%b rd=%h prot=0",
                 i, lat, err, rd, prot, WS + 1, xe, rd_m);
      end
    end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL roundtrip_value got=%h want=deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    logic        w_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  b_t [4] = '{4'hF, 4'h5, 4'h0, 4'hF};
    logic [31:0] d_t [4] = '{32'h11223344, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h0};
    int lat, prot; logic err, xe; logic [31:0] rd; int unsigned rc;
    for (int i = 0; i < 4; i++) begin
      do_access(32'h8FC, w_t[i], b_t[i], d_t[i], lat, err, rd, prot, rc);
      model_access(32'h8FC, w_t[i], b_t[i], d_t[i], xe);
      total++;
      if ({8'(lat), err, rd, 8'(prot)} !== {8'(WS + 1), xe, rd_m, 8'd0}) begin
        bad++;
        $display("FAIL byte_lanes[%0d] got lat=%0d err=%b rd=%h prot=%0d want lat=%0d err=%b rd=%h prot=0",
                 i, lat, err, rd, prot, WS + 1, xe, rd_m);
      end
    end
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL byte_lanes_value got=%h want=11bb33dd", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] a_t [4] = '{32'h600, 32'h600, 32'h602, 32'h600};
    logic        w_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat, prot; logic err, xe; logic [31:0] rd; int unsigned rc;
    for (int i = 0; i < 4; i++) begin
      do_access(a_t[i], w_t[i], 4'hF, (i == 2) ? 32'h12345678 : 32'hCAFE0600,
                lat, err, rd, prot, rc);
      model_access(a_t[i], w_t[i], 4'hF, (i == 2) ? 32'h12345678 : 32'hCAFE0600, xe);
      total++;
      if ({8'(lat), err, rd, 8'(prot)} !== {8'(WS + 1), xe, rd_m, 8'd0}) begin
        bad++;
        $display("FAIL misaligned[%0d] got lat=%0d err=%b rd=%h prot=%0d want lat=%0d err=%b rd=%h prot=0",
                 i, lat, err, rd, prot, WS + 1, xe, rd_m);
      end
    end
  endtask

  task automatic test_busy_drop_back_to_back();
    int lat, prot, readies; logic err, xe; logic [31:0] rd; int unsigned rc1, rc2;
    do_access(32'h504, 1'b1, 4'hF, 32'h0BADF00D, lat, err, rd, prot, rc1);
    model_access(32'h504, 1'b1, 4'hF, 32'h0BADF00D, xe);
    // Accept a write to 0x500, then try a second request while Busy.
    Req = 1'b1; CS = 1'b1; Address = 32'h500; WE = 1'b1; BE = 4'hF; WriteData = 32'hC0FFEE11;
    tick();
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%b want=1", Busy); end
    Address = 32'h504; WriteData = 32'h55555555;
    tick();
    drive_idle();
    readies = 0;
    for (int c = 0; c < 12; c++) begin
      if (Ready === 1'b1) readies++;
      tick();
    end
    model_access(32'h500, 1'b1, 4'hF, 32'hC0FFEE11, xe);
    total++; if (readies != 1) begin bad++; $display("FAIL busy_drop_readies got=%0d want=1", readies); end
    // Back-to-back: do_access returns in the cycle after Ready.
    do_access(32'h500, 1'b0, 4'hF, 32'h0, lat, err, rd, prot, rc1);
    model_access(32'h500, 1'b0, 4'hF, 32'h0, xe);
    total++; if (rd !== rd_m) begin bad++; $display("FAIL b2b_first_rdata got=%h want=%h", rd, rd_m); end
    do_access(32'h504, 1'b0, 4'hF, 32'h0, lat, err, rd, prot, rc2);
    model_access(32'h504, 1'b0, 4'hF, 32'h0, xe);
    total++; if (rc2 - rc1 != 4) begin bad++; $display("FAIL b2b_spacing got=%0d want=4", rc2 - rc1); end
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL dropped_write_absent got=%h want=0badf00d", rd); end
  endtask

  task automatic test_reset_mid_access();
    int lat, prot, seen; logic err, xe; logic [31:0] rd; int unsigned rc;
    do_access(32'h700, 1'b1, 4'hF, 32'h70707070, lat, err, rd, prot, rc);
    model_access(32'h700, 1'b1, 4'hF, 32'h70707070, xe);
    Req = 1'b1; CS = 1'b1; Address = 32'h700; WE = 1'b1; BE = 4'hF; WriteData = 32'hFFFFFFFF;
    tick();
    drive_idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    rd_m = 32'h0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (Ready !== 1'b0 || Busy !== 1'b0) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL reset_mid_no_ready got=%0d want=0", seen); end
    total++; if (ReadData !== rd_m) begin bad++; $display("FAIL reset_mid_rdata got=%h want=%h", ReadData, rd_m); end
    do_access(32'h700, 1'b0, 4'hF, 32'h0, lat, err, rd, prot, rc);
    model_access(32'h700, 1'b0, 4'hF, 32'h0, xe);
    total++; if (rd !== 32'h70707070) begin bad++; $display("FAIL reset_mid_old_value got=%h want=70707070", rd); end
  endtask

  task automatic test_random();
    int lat, prot; logic err, xe; logic [31:0] rd, a, d; int unsigned rc, w; logic we; logic [3:0] be;
    // Give every word in the pool a defined value first.
    for (int i = 0; i < 32; i++) begin
      w = (i < 16) ? i : 224 + i;
      d = $urandom;
      do_access(BASE + 32'(w * 4), 1'b1, 4'hF, d, lat, err, rd, prot, rc);
      model_access(BASE + 32'(w * 4), 1'b1, 4'hF, d, xe);
    end
    for (int i = 0; i < 60; i++) begin
      w  = $urandom_range(0, 31);
      w  = (w < 16) ? w : 224 + w;
      a  = BASE + 32'(w * 4) + (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      we = 1'($urandom);
      be = 4'($urandom);
      d  = $urandom;
      do_access(a, we, be, d, lat, err, rd, prot, rc);
      model_access(a, we, be, d, xe);
      total++;
      if ({8'(lat), err, rd, 8'(prot)} !== {8'(WS + 1), xe, rd_m, 8'd0}) begin
        bad++;
        $display("FAIL random[%0d] a=%h we=%b be=%h got lat=%0d err=%b rd=%h prot=%0d want lat=%0d err=%b rd=%h prot=0",
                 i, a, we, be, lat, err, rd, prot, WS + 1, xe, rd_m);
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    drive_idle();
    test_reset();
    test_cs_low();
    test_roundtrip();
    test_byte_lanes();
    test_misaligned();
    test_busy_drop_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-mapped data memory that answers bus accesses when the address decoder selects it (CS high).
- The decoder window is 0x0000_0500..0x0000_08FF: 1 KB, 256 words × 32 bit.
- Accepts single-cycle read/write strobes and inserts a fixed number of wait states.
- Returns Ready, and Error for misaligned accesses.
- Sits on the MIPS data bus beside other chip-selected peripherals.

Parameters:
- BASE_ADDR, 32'h0000_0500, first byte address of the window.
- DEPTH_WORDS, 256, number of 32-bit words; index width is log2(DEPTH_WORDS).
- WAIT_STATES, 2, cycles between accept and response; legal range 0..15.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CS  in  1  chip select from the address decoder.
- Req  in  1  single-cycle access strobe.
- Address  in  32  byte address.
- WE  in  1  1 = write, 0 = read.
- BE  in  4  byte enables; bit n = byte lane n (bits 8n+7..8n).
- WriteData  in  32  write data.
- ReadData  out  32  read data; valid when Ready=1.
- Ready  out  1  one-cycle response pulse.
- Error  out  1  misaligned access flag; pulses together with Ready.
- Busy  out  1  high from the cycle after accept through the Ready cycle.

Behaviour:
- Reset (synchronous, RST=1 at a rising edge):
  - state=IDLE; Ready, Error and Busy = 0; ReadData = 0; wait counter = 0.
  - Memory array contents are NOT cleared.
- Accept: in IDLE, Req=1 and CS=1 at a rising edge latches Address, WE, BE and WriteData.
  - Req=1 with CS=0 is ignored.
  - Req while not IDLE is dropped silently; no queueing.
- States:
  - IDLE -> WAIT on accept (WAIT_STATES>0); IDLE -> RESP on accept (WAIT_STATES=0).
  - WAIT: counter counts 1..WAIT_STATES, then -> RESP.
  - RESP: Ready=1 for exactly one cycle, then -> IDLE.
  - A new request can be accepted in the cycle after RESP.
- Latency: Ready is high in cycle accept+WAIT_STATES+1. With the default, accept at edge 0 puts Ready in cycle 3.
- Index = (Address - BASE_ADDR) >> 2, truncated to the index width. Address is not range-checked, because CS guarantees the window.
- Misaligned (latched Address[1:0] != 0):
  - Ready=1 and Error=1 in RESP; ReadData=0.
  - No memory write.
- Write:
  - Only byte lanes with BE[n]=1 are updated.
  - BE=0000 is a legal no-op write that still returns Ready.
  - The write commits at the edge that enters RESP, so a following read sees the new data.
  - ReadData is unchanged by a write.
- Read:
  - ReadData is loaded at the edge entering RESP with the full word (BE ignored).
  - ReadData holds its value until the next read response or reset.
- Error is 0 whenever Ready is 0.
- Reset mid-operation: the access is abandoned, no Ready is produced, and a pending write is not committed unless its commit edge already occurred.
- A read of a never-written word returns X in simulation; the bench writes before it reads.

Decomposition:
- Package mips_bus_pkg:
  - DMEM_BASE=32'h500, DMEM_LAST=32'h8FF and DMEM_DEPTH=256; these are shared with the address decoder.
  - State enum {IDLE, WAIT, RESP}.
  - BE width constant.
- Sub-module dmem_array: 256×32 synchronous byte-lane RAM (we, be[3:0], idx, wdata, rdata). The FSM and counter stay in data_mem_responder.

Test Plan:
- Reset, then idle: RST=1 for 2 cycles -> Ready=0, Error=0, Busy=0, ReadData=0; Req with CS=0 at 0x600 -> no Ready for 10 cycles.
- Write/read round trip: write 0xDEADBEEF, BE=1111, at 0x500, then read 0x500 -> Ready exactly in cycle accept+3 each time; ReadData=0xDEADBEEF; Error=0.
- Byte lanes: write 0x11223344 at 0x8FC, then write 0xAABBCCDD with BE=0101, then read -> 0x11BB33DD. Address 0x8FC maps to word 255.
- Misaligned: write 0x12345678 at 0x602 -> Ready=1, Error=1, ReadData=0; a read of 0x600 shows the previous contents unchanged.
- Busy drop and back-to-back: Req at 0x504 while Busy=1 -> ignored, only one Ready. Req in the cycle after Ready -> accepted, second Ready 4 cycles later.
- Reset mid-access: accept a write to 0x700, then assert RST in cycle accept+1 -> no Ready, state IDLE; reading 0x700 returns the old value.
